// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN
  } par_mode_t;

  localparam string STR_LSB  = "LSB";
  localparam string STR_MSB  = "MSB";
  localparam string STR_NO   = "NO";
  localparam string STR_ODD  = "ODD";
  localparam string STR_EVEN = "EVEN";

  // Clocks per bit, rounded to nearest.
  function automatic int calc_div(input int clock, input int baud);
    return (clock + baud / 2) / baud;
  endfunction

  function automatic logic par_bit(input logic [7:0] data, input par_mode_t mode);
    return (mode == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_fifo.sv
// Byte FIFO with wrap-bit pointers; head word is readable combinationally.
module tx_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int AW = LW - 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // The extra pointer bit tells a full FIFO apart from an empty one.
  assign full_o  = (wr_ptr_q[LW-1] != rd_ptr_q[LW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO; queued bytes are sent as gapless frames.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int    CLOCK      = 10_000_000,
  parameter int    BAUD       = 1_000_000,
  parameter string FIRST_BIT  = "LSB",
  parameter string PARITY     = "NO",
  parameter int    STOP_BITS  = 1,
  parameter int    FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int        DIV       = calc_div(CLOCK, BAUD);
  localparam int        STOP_LEN  = STOP_BITS * DIV;
  localparam int        CW        = $clog2(STOP_LEN);
  localparam bit        MSB_FIRST = (FIRST_BIT == STR_MSB);
  localparam par_mode_t PAR_MODE  = (PARITY == STR_ODD)  ? PAR_ODD :
                                    (PARITY == STR_EVEN) ? PAR_EVEN : PAR_NONE;
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("uart_tx_fifo: CLOCK/BAUD gives fewer than 2 clocks per bit");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
    end
    if (FIRST_BIT != STR_LSB && FIRST_BIT != STR_MSB) begin : g_bad_order
      $error("uart_tx_fifo: FIRST_BIT must be LSB or MSB");
    end
    if (PARITY != STR_NO && PARITY != STR_ODD && PARITY != STR_EVEN) begin : g_bad_par
      $error("uart_tx_fifo: PARITY must be NO, ODD or EVEN");
    end
  endgenerate

  tx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bitn_q, bitn_d;
  logic          par_q, par_d;
  logic          txd_q, txd_d;
  logic          done_q, done_d;
  logic          line_busy_q;

  logic          push, pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full, fifo_empty;

  assign tx_ready = !fifo_full;
  assign push     = tx_valid && !fifo_full;

  tx_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (tx_data),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    shift_d = shift_q;
    bitn_d  = bitn_q;
    par_d   = par_q;
    txd_d   = 1'b1;
    done_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          par_d   = par_bit(fifo_dout, PAR_MODE);
          state_d = S_START;
        end
      end
      S_START: begin
        txd_d = 1'b0;
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          bitn_d  = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        txd_d = MSB_FIRST ? shift_q[7] : shift_q[0];
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          bitn_d  = bitn_q + 3'd1;
          shift_d = MSB_FIRST ? {shift_q[6:0], 1'b0} : {1'b0, shift_q[7:1]};
          if (bitn_q == 3'd7) state_d = (PAR_MODE != PAR_NONE) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        txd_d = par_q;
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == STOP_LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
          // Reload in the last stop clock so the next start bit follows with no gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            par_d   = par_bit(fifo_dout, PAR_MODE);
            state_d = S_START;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // txd and done are registered, so the line runs one clock behind the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      bitn_q      <= '0;
      par_q       <= 1'b0;
      txd_q       <= 1'b1;
      done_q      <= 1'b0;
      line_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      bitn_q      <= bitn_d;
      par_q       <= par_d;
      txd_q       <= txd_d;
      done_q      <= done_d;
      line_busy_q <= (state_q != S_IDLE);
    end
  end

  assign txd  = txd_q;
  assign done = done_q;
  // line_busy_q keeps busy high through the final stop clock on the line.
  assign busy = (state_q != S_IDLE) || (fifo_level != '0) || line_busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised self-checking bench: four transmitter configurations against a frame-level model.
module tb_uart_tx_fifo;

  typedef logic [7:0] bq_t[$];

  localparam int DIV = 10;
  localparam int PAR_K   [4] = '{0, 2, 1, 0};   // 0 none, 1 odd, 2 even
  localparam int MSB_K   [4] = '{0, 0, 0, 1};
  localparam int STOP_K  [4] = '{1, 1, 1, 2};
  localparam int DEPTH_K [4] = '{4, 8, 4, 4};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data  [4];
  logic       tx_valid [4];
  logic       tx_ready [4];
  logic       txd      [4];
  logic       busy     [4];
  logic       done     [4];
  logic [2:0] lvl0, lvl2, lvl3;
  logic [3:0] lvl1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.PARITY("NO")) u0 (
    .clk(clk), .reset(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .txd(txd[0]), .busy(busy[0]), .done(done[0]), .fifo_level(lvl0));
  uart_tx_fifo #(.PARITY("EVEN"), .FIFO_DEPTH(8)) u1 (
    .clk(clk), .reset(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .txd(txd[1]), .busy(busy[1]), .done(done[1]), .fifo_level(lvl1));
  uart_tx_fifo #(.PARITY("ODD")) u2 (
    .clk(clk), .reset(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
    .txd(txd[2]), .busy(busy[2]), .done(done[2]), .fifo_level(lvl2));
  uart_tx_fifo #(.FIRST_BIT("MSB"), .STOP_BITS(2)) u3 (
    .clk(clk), .reset(rst), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]), .tx_ready(tx_ready[3]),
    .txd(txd[3]), .busy(busy[3]), .done(done[3]), .fifo_level(lvl3));

  function automatic int get_level(input int k);
    case (k)
      0:       return int'(lvl0);
      1:       return int'(lvl1);
      2:       return int'(lvl2);
      default: return int'(lvl3);
    endcase
  endfunction

  function automatic int flen(input int k);
    return (1 + 8 + ((PAR_K[k] != 0) ? 1 : 0) + STOP_K[k]) * DIV;
  endfunction

  // Line level of bit slot idx of a frame carrying byte b.
  function automatic logic frame_bit(input int k, input logic [7:0] b, input int idx);
    int ones;
    ones = $countones(b);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return (MSB_K[k] != 0) ? b[8 - idx] : b[idx - 1];
    if (PAR_K[k] != 0 && idx == 9) return (PAR_K[k] == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
    return 1'b1;
  endfunction

  // Streams bytes into instance k; a frame whose byte was accepted at edge a starts
  // on the line at max(a+2, end of previous frame).
  task automatic run_stream(input int k, input bq_t bytes, input bit gaps, input int reset_at,
                            output int n_done, output int first_acc, output int first_start,
                            output int last_done);
    int L, depth, line_end, nxt, t, exp_lvl, start_at;
    logic [7:0] fifo_b[$];
    int fifo_a[$];
    int fr_s[$];
    logic [7:0] fr_b[$];
    bit drv, accepted, ready_cur, in_now, in_next;
    logic exp_txd, exp_done, exp_busy;
    L = flen(k); depth = DEPTH_K[k];
    line_end = 0; nxt = 0; t = 0;
    drv = 1'b0; accepted = 1'b0; ready_cur = 1'b1;
    n_done = 0; first_acc = -1; first_start = -1; last_done = -1;
    while (1) begin
      if (!(drv && !accepted)) begin
        if (nxt < bytes.size() && (!gaps || $urandom_range(0, 2) == 0)) begin
          drv = 1'b1; tx_data[k] = bytes[nxt];
        end else begin
          drv = 1'b0; tx_data[k] = 8'($urandom);
        end
      end
      tx_valid[k] = drv;
      @(posedge clk);
      t++;
      accepted = drv && ready_cur;
      if (accepted) begin
        fifo_b.push_back(bytes[nxt]);
        fifo_a.push_back(t);
        if (first_acc < 0) first_acc = t;
        nxt++;
      end
      if (fifo_b.size() > 0) begin
        start_at = (fifo_a[0] + 2 > line_end) ? fifo_a[0] + 2 : line_end;
        if (t >= start_at - 1) begin
          fr_s.push_back(t + 1);
          fr_b.push_back(fifo_b.pop_front());
          void'(fifo_a.pop_front());
          line_end = t + 1 + L;
        end
      end
      #1;
      while (fr_s.size() > 0 && fr_s[0] + L <= t) begin
        void'(fr_s.pop_front());
        void'(fr_b.pop_front());
      end
      exp_txd = 1'b1; exp_done = 1'b0; in_now = 1'b0; in_next = 1'b0;
      foreach (fr_s[i]) begin
        if (fr_s[i] <= t && t < fr_s[i] + L) begin
          in_now   = 1'b1;
          exp_txd  = frame_bit(k, fr_b[i], (t - fr_s[i]) / DIV);
          exp_done = (t == fr_s[i] + L - 1);
        end
        if (fr_s[i] <= t + 1 && t + 1 < fr_s[i] + L) in_next = 1'b1;
      end
      exp_lvl   = fifo_b.size();
      ready_cur = (exp_lvl < depth);
      exp_busy  = in_now || in_next || (exp_lvl != 0);

      n_checks++;
      if (txd[k] !== exp_txd) begin
        n_fail++; $display("FAIL txd k=%0d t=%0d got %b expected %b", k, t, txd[k], exp_txd);
      end
      n_checks++;
      if (done[k] !== exp_done) begin
        n_fail++; $display("FAIL done k=%0d t=%0d got %b expected %b", k, t, done[k], exp_done);
      end
      n_checks++;
      if (tx_ready[k] !== ready_cur) begin
        n_fail++; $display("FAIL tx_ready k=%0d t=%0d got %b expected %b", k, t, tx_ready[k], ready_cur);
      end
      n_checks++;
      if (get_level(k) !== exp_lvl) begin
        n_fail++; $display("FAIL fifo_level k=%0d t=%0d got %0d expected %0d", k, t, get_level(k), exp_lvl);
      end
      n_checks++;
      if (busy[k] !== exp_busy) begin
        n_fail++; $display("FAIL busy k=%0d t=%0d got %b expected %b", k, t, busy[k], exp_busy);
      end

      if (txd[k] === 1'b0 && first_start < 0) first_start = t;
      if (done[k] === 1'b1) begin
        n_done++; last_done = t;
      end

      if (reset_at >= 0 && t == reset_at) begin
        rst = 1'b1; tx_valid[k] = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (txd[k] !== 1'b1 || done[k] !== 1'b0 || busy[k] !== 1'b0 || get_level(k) != 0 || tx_ready[k] !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_mid k=%0d got txd=%b done=%b busy=%b lvl=%0d rdy=%b expected 1 0 0 0 1",
                   k, txd[k], done[k], busy[k], get_level(k), tx_ready[k]);
        end
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
          @(posedge clk); #1;
          n_checks++;
          if (txd[k] !== 1'b1 || done[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset k=%0d c=%0d got txd=%b done=%b expected 1 0", k, c, txd[k], done[k]);
          end
        end
        return;
      end
      if (nxt == bytes.size() && fifo_b.size() == 0 && t >= line_end) break;
      if (t > 5000) begin
        n_checks++; n_fail++;
        $display("FAIL timeout k=%0d t=%0d got pending bytes expected drained", k, t);
        break;
      end
    end
    tx_valid[k] = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (txd[k] !== 1'b1 || tx_ready[k] !== 1'b1 || busy[k] !== 1'b0 || done[k] !== 1'b0 || get_level(k) != 0) begin
        n_fail++;
        $display("FAIL reset_values k=%0d got txd=%b rdy=%b busy=%b done=%b lvl=%0d expected 1 1 0 0 0",
                 k, txd[k], tx_ready[k], busy[k], done[k], get_level(k));
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic check_frames(input string name, input int k, input int nd, input int fa, input int fs,
                              input int ld, input int nbytes);
    n_checks++;
    if (fs !== fa + 2) begin
      n_fail++; $display("FAIL %s latency got start=%0d expected %0d", name, fs, fa + 2);
    end
    n_checks++;
    if (nd != nbytes) begin
      n_fail++; $display("FAIL %s done_count got %0d expected %0d", name, nd, nbytes);
    end
    n_checks++;
    if (ld - fs + 1 != nbytes * flen(k)) begin
      n_fail++; $display("FAIL %s span got %0d expected %0d", name, ld - fs + 1, nbytes * flen(k));
    end
    $display("%s: k=%0d bytes=%0d span=%0d", name, k, nbytes, ld - fs + 1);
  endtask

  task automatic test_single_8n1;
    int nd, fa, fs, ld;
    bq_t q;
    q = '{8'h53};
    run_stream(0, q, 1'b0, -1, nd, fa, fs, ld);
    check_frames("single_8n1", 0, nd, fa, fs, ld, 1);
  endtask

  task automatic test_back_to_back;
    int nd, fa, fs, ld;
    bq_t q;
    q = '{8'h53, 8'h9B, 8'h46};
    run_stream(0, q, 1'b0, -1, nd, fa, fs, ld);
    check_frames("back_to_back", 0, nd, fa, fs, ld, 3);
  endtask

  task automatic test_parity;
    int nd, fa, fs, ld;
    bq_t q;
    q = '{8'h9B};
    run_stream(1, q, 1'b0, -1, nd, fa, fs, ld);
    check_frames("parity_even", 1, nd, fa, fs, ld, 1);
    run_stream(2, q, 1'b0, -1, nd, fa, fs, ld);
    check_frames("parity_odd", 2, nd, fa, fs, ld, 1);
  endtask

  task automatic test_msb_2stop;
    int nd, fa, fs, ld;
    bq_t q;
    q = '{8'h46};
    run_stream(3, q, 1'b0, -1, nd, fa, fs, ld);
    check_frames("msb_2stop", 3, nd, fa, fs, ld, 1);
  endtask

  task automatic test_burst;
    int nd, fa, fs, ld;
    bq_t q;
    q = {};
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
    run_stream(0, q, 1'b0, -1, nd, fa, fs, ld);
    check_frames("burst6", 0, nd, fa, fs, ld, 6);
  endtask

  task automatic test_reset_mid_frame;
    int nd, fa, fs, ld;
    bq_t q;
    q = '{8'h53, 8'($urandom), 8'($urandom)};
    // first byte accepted at edge 1, so its start bit is at 3; clock 35 of the frame is 3+34
    run_stream(0, q, 1'b0, 3 + 34, nd, fa, fs, ld);
    n_checks++;
    if (nd != 0) begin
      n_fail++; $display("FAIL reset_mid done_count got %0d expected 0", nd);
    end
    q = '{8'hA5};
    run_stream(0, q, 1'b0, -1, nd, fa, fs, ld);
    check_frames("after_reset_A5", 0, nd, fa, fs, ld, 1);
  endtask

  task automatic test_random;
    int nd, fa, fs, ld;
    bq_t q;
    for (int k = 0; k < 4; k++) begin
      q = {};
      for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
      run_stream(k, q, 1'b1, -1, nd, fa, fs, ld);
      n_checks++;
      if (nd != 8) begin
        n_fail++; $display("FAIL random done_count k=%0d got %0d expected 8", k, nd);
      end
      $display("random: k=%0d frames=%0d", k, nd);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      tx_valid[k] = 1'b0;
      tx_data[k]  = 8'h00;
    end
    test_reset();
    test_single_8n1();
    test_back_to_back();
    test_parity();
    test_msb_2stop();
    test_burst();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
